// File: rtl/traffic_light_safety_monitor.sv
// traffic_light_safety_monitor
// Sits between the two-road light controller and the lamp drivers. Lamp codes
// pass through with one cycle of latency while being checked for illegal or
// unsafe patterns. A violation latches a cause code and flashes yellow/red
// until acknowledged, then all-red is held before pass-through resumes.
// Optional build macro FAULT_CNT_EN adds output fault_cnt, an 8-bit saturating
// count of fault entries cleared only by rs.
module traffic_light_safety_monitor #(
   parameter int unsigned MIN_YELLOW = 4,
   parameter int unsigned MAX_DWELL  = 31,
   parameter int unsigned FLASH_HALF = 4,
   parameter int unsigned ALL_RED    = 8,
   parameter int unsigned CNT_W      = 6
) (
   input  logic       clk,
   input  logic       rs,
   input  logic [2:0] in_1,
   input  logic [2:0] in_2,
   input  logic       ack,
   output logic [2:0] out_1,
   output logic [2:0] out_2,
   output logic       fault,
   output logic [2:0] fault_code
`ifdef FAULT_CNT_EN
   ,
   output logic [7:0] fault_cnt
`endif
);

   // Lamp encoding: bit2 red, bit1 green, bit0 yellow
   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_GRN = 3'b010;
   localparam logic [2:0] LAMP_YEL = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   localparam logic [CNT_W-1:0] LP_MIN_YELLOW = CNT_W'(MIN_YELLOW);
   localparam logic [CNT_W-1:0] LP_MAX_DWELL  = CNT_W'(MAX_DWELL);
   localparam logic [CNT_W-1:0] LP_FLASH_LAST = CNT_W'(FLASH_HALF - 1);
   localparam logic [CNT_W-1:0] LP_RED_LAST   = CNT_W'(ALL_RED - 1);
   localparam logic [CNT_W-1:0] LP_ONE        = CNT_W'(1);

   typedef enum logic [1:0] {
      StMon,
      StFaultFlash,
      StRecover
   } state_t;

   state_t           r_state;
   logic [2:0]       r_out_1;
   logic [2:0]       r_out_2;
   logic             r_fault;
   logic [2:0]       r_fault_code;
   logic [2:0]       r_prev_1;
   logic [2:0]       r_prev_2;
   logic [CNT_W-1:0] r_dwell;
   logic [CNT_W-1:0] r_ycnt_1;
   logic [CNT_W-1:0] r_ycnt_2;
   logic [CNT_W-1:0] r_cnt;      // flash half-period / all-red timer
   logic             r_flash_on;

   logic       w_oh_1;
   logic       w_oh_2;
   logic       w_g2r;
   logic       w_short_yel;
   logic       w_same;
   logic       w_legal;
   logic [2:0] w_code;

   assign w_oh_1 = (in_1 == LAMP_RED) || (in_1 == LAMP_GRN) || (in_1 == LAMP_YEL);
   assign w_oh_2 = (in_2 == LAMP_RED) || (in_2 == LAMP_GRN) || (in_2 == LAMP_YEL);

   assign w_g2r = ((r_prev_1 == LAMP_GRN) && (in_1 == LAMP_RED)) ||
                  ((r_prev_2 == LAMP_GRN) && (in_2 == LAMP_RED));

   // r_ycnt_x counts consecutive cycles prev_x has been yellow
   assign w_short_yel = ((r_prev_1 == LAMP_YEL) && (in_1 != LAMP_YEL) &&
                         (r_ycnt_1 < LP_MIN_YELLOW)) ||
                        ((r_prev_2 == LAMP_YEL) && (in_2 != LAMP_YEL) &&
                         (r_ycnt_2 < LP_MIN_YELLOW));

   assign w_same  = ({in_1, in_2} == {r_prev_1, r_prev_2});
   assign w_legal = w_oh_1 && w_oh_2 && (in_1[2] || in_2[2]);

   // Prioritised fault cause; the lowest code wins, 0 means no fault
   always_comb begin
      w_code = 3'd0;
      if (!w_oh_1 || !w_oh_2) begin
         w_code = 3'd1;
      end else if (!in_1[2] && !in_2[2]) begin
         w_code = 3'd2;
      end else if (w_g2r) begin
         w_code = 3'd3;
      end else if (w_short_yel) begin
         w_code = 3'd4;
      end else if (r_dwell == LP_MAX_DWELL) begin
         w_code = 3'd5;
      end
   end

   // Monitor / fault-flash / recovery state machine with registered outputs
   always_ff @(posedge clk) begin
      if (rs) begin
         r_state      <= StMon;
         r_out_1      <= LAMP_RED;
         r_out_2      <= LAMP_RED;
         r_fault      <= 1'b0;
         r_fault_code <= 3'd0;
         r_prev_1     <= LAMP_RED;
         r_prev_2     <= LAMP_RED;
         r_dwell      <= '0;
         r_ycnt_1     <= '0;
         r_ycnt_2     <= '0;
         r_cnt        <= '0;
         r_flash_on   <= 1'b0;
      end else begin
         case (r_state)
            StMon: begin
               if (w_code != 3'd0) begin
                  r_state      <= StFaultFlash;
                  r_fault      <= 1'b1;
                  r_fault_code <= w_code;
                  r_out_1      <= LAMP_YEL;
                  r_out_2      <= LAMP_RED;
                  r_cnt        <= '0;
                  r_flash_on   <= 1'b1;
               end else begin
                  r_out_1  <= in_1;
                  r_out_2  <= in_2;
                  r_prev_1 <= in_1;
                  r_prev_2 <= in_2;
                  if (!w_same) begin
                     r_dwell <= '0;
                  end else if (r_dwell != LP_MAX_DWELL) begin
                     r_dwell <= r_dwell + LP_ONE;
                  end
                  if (in_1 != LAMP_YEL) begin
                     r_ycnt_1 <= '0;
                  end else if (r_ycnt_1 != '1) begin
                     r_ycnt_1 <= r_ycnt_1 + LP_ONE;
                  end
                  if (in_2 != LAMP_YEL) begin
                     r_ycnt_2 <= '0;
                  end else if (r_ycnt_2 != '1) begin
                     r_ycnt_2 <= r_ycnt_2 + LP_ONE;
                  end
               end
            end
            StFaultFlash: begin
               if (ack) begin
                  r_state <= StRecover;
                  r_fault <= 1'b0;
                  r_out_1 <= LAMP_RED;
                  r_out_2 <= LAMP_RED;
                  r_cnt   <= '0;
               end else if (r_cnt == LP_FLASH_LAST) begin
                  r_cnt      <= '0;
                  r_flash_on <= !r_flash_on;
                  r_out_1    <= r_flash_on ? LAMP_OFF : LAMP_YEL;
                  r_out_2    <= r_flash_on ? LAMP_OFF : LAMP_RED;
               end else begin
                  r_cnt <= r_cnt + LP_ONE;
               end
            end
            StRecover: begin
               r_out_1 <= LAMP_RED;
               r_out_2 <= LAMP_RED;
               if (r_cnt < LP_RED_LAST) begin
                  r_cnt <= r_cnt + LP_ONE;
               end else if (w_legal) begin
                  // Restart checking from a clean all-red history
                  r_state      <= StMon;
                  r_fault_code <= 3'd0;
                  r_prev_1     <= LAMP_RED;
                  r_prev_2     <= LAMP_RED;
                  r_dwell      <= '0;
                  r_ycnt_1     <= '0;
                  r_ycnt_2     <= '0;
               end
            end
            default: begin
               r_state <= StMon;
            end
         endcase
      end
   end

   assign out_1      = r_out_1;
   assign out_2      = r_out_2;
   assign fault      = r_fault;
   assign fault_code = r_fault_code;

`ifdef FAULT_CNT_EN
   logic       w_enter;
   logic [7:0] r_fault_cnt;

   assign w_enter = (r_state == StMon) && (w_code != 3'd0);

   // Saturating count of fault entries; ack does not clear it
   always_ff @(posedge clk) begin
      if (rs) begin
         r_fault_cnt <= 8'd0;
      end else if (w_enter && (r_fault_cnt != 8'hFF)) begin
         r_fault_cnt <= r_fault_cnt + 8'd1;
      end
   end

   assign fault_cnt = r_fault_cnt;
`endif

endmodule

// File: tb/tb_traffic_light_safety_monitor.sv
// Bench for traffic_light_safety_monitor: each scenario task queues stimulus
// steps, pushes the expected {out_1,out_2,fault,fault_code} to a scoreboard
// when a step is driven, and pops/compares after the capturing clock edge.
module tb_traffic_light_safety_monitor;

   logic       clk;
   logic       rs;
   logic [2:0] in_1;
   logic [2:0] in_2;
   logic       ack;
   logic [2:0] out_1;
   logic [2:0] out_2;
   logic       fault;
   logic [2:0] fault_code;
`ifdef FAULT_CNT_EN
   logic [7:0] fault_cnt;
`endif

   int total;
   int bad;

   typedef struct {
      logic [2:0] i1;
      logic [2:0] i2;
      logic       a;
      logic       r;
      logic [9:0] e;
   } step_t;

   step_t      step_q[$];
   logic [9:0] exp_q[$];

   traffic_light_safety_monitor dut (
      .clk        (clk),
      .rs         (rs),
      .in_1       (in_1),
      .in_2       (in_2),
      .ack        (ack),
      .out_1      (out_1),
      .out_2      (out_2),
      .fault      (fault),
      .fault_code (fault_code)
`ifdef FAULT_CNT_EN
      ,
      .fault_cnt  (fault_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected observation {out_1, out_2, fault, fault_code}
   function automatic logic [9:0] ex(input logic [2:0] o1, input logic [2:0] o2,
                                     input logic f, input logic [2:0] c);
      return {o1, o2, f, c};
   endfunction

   function automatic void add(input logic [2:0] i1, input logic [2:0] i2, input logic a,
                               input logic r, input logic [9:0] e);
      step_t s;
      s.i1 = i1;
      s.i2 = i2;
      s.a  = a;
      s.r  = r;
      s.e  = e;
      step_q.push_back(s);
   endfunction

   task automatic test_reset();
      step_t s;
      logic [9:0] got, want;
      int n = 0;
      add(3'b011, 3'b011, 1'b1, 1'b1, ex(3'b100, 3'b100, 1'b0, 3'd0));
      add(3'b010, 3'b010, 1'b0, 1'b1, ex(3'b100, 3'b100, 1'b0, 3'd0));
      while (step_q.size() != 0) begin
         s = step_q.pop_front();
         in_1 = s.i1; in_2 = s.i2; ack = s.a; rs = s.r;
         exp_q.push_back(s.e);
         n++;
         @(posedge clk);
         #1;
         want = exp_q.pop_front();
         got  = {out_1, out_2, fault, fault_code};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL reset step=%0d got=%b/%b f=%b c=%0d want=%b/%b f=%b c=%0d", n,
                     got[9:7], got[6:4], got[3], got[2:0],
                     want[9:7], want[6:4], want[3], want[2:0]);
         end
      end
`ifdef FAULT_CNT_EN
      total++;
      if (fault_cnt !== 8'd0) begin
         bad++;
         $display("FAIL reset_fault_cnt got=%0d want=0", fault_cnt);
      end
`endif
   endtask

   // Normal controller cycle; ack is held high in the second pass and must be ignored
   task automatic test_pass_through();
      step_t s;
      logic [9:0] got, want;
      logic [2:0] ph1[4], ph2[4];
      int len[4];
      int n = 0;
      ph1 = '{3'b010, 3'b001, 3'b100, 3'b100};
      ph2 = '{3'b100, 3'b100, 3'b010, 3'b001};
      len = '{16, 6, 16, 6};
      for (int rep = 0; rep < 2; rep++)
         for (int p = 0; p < 4; p++)
            for (int k = 0; k < len[p]; k++)
               add(ph1[p], ph2[p], rep[0], 1'b0, ex(ph1[p], ph2[p], 1'b0, 3'd0));
      while (step_q.size() != 0) begin
         s = step_q.pop_front();
         in_1 = s.i1; in_2 = s.i2; ack = s.a; rs = s.r;
         exp_q.push_back(s.e);
         n++;
         @(posedge clk);
         #1;
         want = exp_q.pop_front();
         got  = {out_1, out_2, fault, fault_code};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL pass_through step=%0d got=%b/%b f=%b c=%0d want=%b/%b f=%b c=%0d", n,
                     got[9:7], got[6:4], got[3], got[2:0],
                     want[9:7], want[6:4], want[3], want[2:0]);
         end
      end
   endtask

   // Non-one-hot code, then the flash pattern: on 4 cycles, dark 4, on again
   task automatic test_flash();
      step_t s;
      logic [9:0] got, want;
      int n = 0;
      add(3'b011, 3'b100, 1'b0, 1'b0, ex(3'b001, 3'b100, 1'b1, 3'd1));
      for (int k = 1; k <= 8; k++) begin
         if (k >= 4 && k <= 7) add(3'b100, 3'b100, 1'b0, 1'b0, ex(3'b000, 3'b000, 1'b1, 3'd1));
         else                  add(3'b010, 3'b010, 1'b0, 1'b0, ex(3'b001, 3'b100, 1'b1, 3'd1));
      end
      add(3'b100, 3'b100, 1'b0, 1'b1, ex(3'b100, 3'b100, 1'b0, 3'd0));
      while (step_q.size() != 0) begin
         s = step_q.pop_front();
         in_1 = s.i1; in_2 = s.i2; ack = s.a; rs = s.r;
         exp_q.push_back(s.e);
         n++;
         @(posedge clk);
         #1;
         want = exp_q.pop_front();
         got  = {out_1, out_2, fault, fault_code};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL flash step=%0d got=%b/%b f=%b c=%0d want=%b/%b f=%b c=%0d", n,
                     got[9:7], got[6:4], got[3], got[2:0],
                     want[9:7], want[6:4], want[3], want[2:0]);
         end
      end
   endtask

   // Both green -> 2; non-one-hot beats both-non-red -> 1
   task automatic test_code_priority();
      step_t s;
      logic [9:0] got, want;
      int n = 0;
      add(3'b010, 3'b010, 1'b0, 1'b0, ex(3'b001, 3'b100, 1'b1, 3'd2));
      add(3'b100, 3'b100, 1'b0, 1'b1, ex(3'b100, 3'b100, 1'b0, 3'd0));
      add(3'b110, 3'b010, 1'b0, 1'b0, ex(3'b001, 3'b100, 1'b1, 3'd1));
      add(3'b100, 3'b100, 1'b0, 1'b1, ex(3'b100, 3'b100, 1'b0, 3'd0));
      add(3'b011, 3'b010, 1'b0, 1'b0, ex(3'b001, 3'b100, 1'b1, 3'd1));
      add(3'b100, 3'b100, 1'b0, 1'b1, ex(3'b100, 3'b100, 1'b0, 3'd0));
      while (step_q.size() != 0) begin
         s = step_q.pop_front();
         in_1 = s.i1; in_2 = s.i2; ack = s.a; rs = s.r;
         exp_q.push_back(s.e);
         n++;
         @(posedge clk);
         #1;
         want = exp_q.pop_front();
         got  = {out_1, out_2, fault, fault_code};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL code_priority step=%0d got=%b/%b f=%b c=%0d want=%b/%b f=%b c=%0d", n,
                     got[9:7], got[6:4], got[3], got[2:0],
                     want[9:7], want[6:4], want[3], want[2:0]);
         end
      end
   endtask

   // Green->red on each road (3); yellow of 2 and 3 cycles (4); yellow of 4 is legal
   task automatic test_transitions();
      step_t s;
      logic [9:0] got, want;
      int n = 0;
      for (int k = 0; k < 3; k++) add(3'b010, 3'b100, 1'b0, 1'b0, ex(3'b010, 3'b100, 1'b0, 3'd0));
      add(3'b100, 3'b100, 1'b0, 1'b0, ex(3'b001, 3'b100, 1'b1, 3'd3));
      add(3'b100, 3'b100, 1'b0, 1'b1, ex(3'b100, 3'b100, 1'b0, 3'd0));
      add(3'b100, 3'b010, 1'b0, 1'b0, ex(3'b100, 3'b010, 1'b0, 3'd0));
      add(3'b100, 3'b100, 1'b0, 1'b0, ex(3'b001, 3'b100, 1'b1, 3'd3));
      add(3'b100, 3'b100, 1'b0, 1'b1, ex(3'b100, 3'b100, 1'b0, 3'd0));
      for (int y = 2; y <= 4; y++) begin
         for (int k = 0; k < y; k++) add(3'b001, 3'b100, 1'b0, 1'b0, ex(3'b001, 3'b100, 1'b0, 3'd0));
         if (y < 4) add(3'b100, 3'b100, 1'b0, 1'b0, ex(3'b001, 3'b100, 1'b1, 3'd4));
         else       add(3'b100, 3'b100, 1'b0, 1'b0, ex(3'b100, 3'b100, 1'b0, 3'd0));
         add(3'b100, 3'b100, 1'b0, 1'b1, ex(3'b100, 3'b100, 1'b0, 3'd0));
      end
      while (step_q.size() != 0) begin
         s = step_q.pop_front();
         in_1 = s.i1; in_2 = s.i2; ack = s.a; rs = s.r;
         exp_q.push_back(s.e);
         n++;
         @(posedge clk);
         #1;
         want = exp_q.pop_front();
         got  = {out_1, out_2, fault, fault_code};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL transitions step=%0d got=%b/%b f=%b c=%0d want=%b/%b f=%b c=%0d", n,
                     got[9:7], got[6:4], got[3], got[2:0],
                     want[9:7], want[6:4], want[3], want[2:0]);
         end
      end
   endtask

   // Stuck input: 32 cycles pass, 33rd faults with code 5; ack -> all-red -> resume
   task automatic test_stuck_and_recover();
      step_t s;
      logic [9:0] got, want;
      int n = 0;
      add(3'b100, 3'b100, 1'b0, 1'b1, ex(3'b100, 3'b100, 1'b0, 3'd0));
      for (int k = 0; k < 32; k++) add(3'b010, 3'b100, 1'b0, 1'b0, ex(3'b010, 3'b100, 1'b0, 3'd0));
      add(3'b010, 3'b100, 1'b0, 1'b0, ex(3'b001, 3'b100, 1'b1, 3'd5));
      add(3'b010, 3'b100, 1'b1, 1'b0, ex(3'b100, 3'b100, 1'b0, 3'd5));
      for (int k = 0; k < 7; k++) add(3'b010, 3'b100, 1'b0, 1'b0, ex(3'b100, 3'b100, 1'b0, 3'd5));
      add(3'b010, 3'b100, 1'b0, 1'b0, ex(3'b100, 3'b100, 1'b0, 3'd0));
      add(3'b010, 3'b100, 1'b0, 1'b0, ex(3'b010, 3'b100, 1'b0, 3'd0));
      add(3'b001, 3'b100, 1'b0, 1'b0, ex(3'b001, 3'b100, 1'b0, 3'd0));
      while (step_q.size() != 0) begin
         s = step_q.pop_front();
         in_1 = s.i1; in_2 = s.i2; ack = s.a; rs = s.r;
         exp_q.push_back(s.e);
         n++;
         @(posedge clk);
         #1;
         want = exp_q.pop_front();
         got  = {out_1, out_2, fault, fault_code};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL stuck_recover step=%0d got=%b/%b f=%b c=%0d want=%b/%b f=%b c=%0d", n,
                     got[9:7], got[6:4], got[3], got[2:0],
                     want[9:7], want[6:4], want[3], want[2:0]);
         end
      end
   endtask

   // Recovery waits past all-red while inputs stay illegal, then exits on legal ones
   task automatic test_recover_wait();
      step_t s;
      logic [9:0] got, want;
      int n = 0;
      add(3'b100, 3'b100, 1'b0, 1'b1, ex(3'b100, 3'b100, 1'b0, 3'd0));
      add(3'b011, 3'b100, 1'b0, 1'b0, ex(3'b001, 3'b100, 1'b1, 3'd1));
      add(3'b010, 3'b010, 1'b1, 1'b0, ex(3'b100, 3'b100, 1'b0, 3'd1));
      for (int k = 0; k < 11; k++)
         add(3'b010, 3'b010, k[0], 1'b0, ex(3'b100, 3'b100, 1'b0, 3'd1));
      add(3'b100, 3'b010, 1'b0, 1'b0, ex(3'b100, 3'b100, 1'b0, 3'd0));
      add(3'b100, 3'b010, 1'b0, 1'b0, ex(3'b100, 3'b010, 1'b0, 3'd0));
      while (step_q.size() != 0) begin
         s = step_q.pop_front();
         in_1 = s.i1; in_2 = s.i2; ack = s.a; rs = s.r;
         exp_q.push_back(s.e);
         n++;
         @(posedge clk);
         #1;
         want = exp_q.pop_front();
         got  = {out_1, out_2, fault, fault_code};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL recover_wait step=%0d got=%b/%b f=%b c=%0d want=%b/%b f=%b c=%0d", n,
                     got[9:7], got[6:4], got[3], got[2:0],
                     want[9:7], want[6:4], want[3], want[2:0]);
         end
      end
   endtask

   // rs mid-flash and mid-recovery; then three fault entries for the counter
   task automatic test_reset_mid();
      step_t s;
      logic [9:0] got, want;
      int n = 0;
      int nfaults = 0;
      add(3'b011, 3'b100, 1'b0, 1'b0, ex(3'b001, 3'b100, 1'b1, 3'd1));
      add(3'b100, 3'b100, 1'b0, 1'b0, ex(3'b001, 3'b100, 1'b1, 3'd1));
      add(3'b100, 3'b100, 1'b0, 1'b1, ex(3'b100, 3'b100, 1'b0, 3'd0));
      add(3'b010, 3'b100, 1'b0, 1'b0, ex(3'b010, 3'b100, 1'b0, 3'd0));
      add(3'b010, 3'b010, 1'b0, 1'b0, ex(3'b001, 3'b100, 1'b1, 3'd2));
      add(3'b100, 3'b100, 1'b1, 1'b0, ex(3'b100, 3'b100, 1'b0, 3'd2));
      add(3'b100, 3'b100, 1'b0, 1'b0, ex(3'b100, 3'b100, 1'b0, 3'd2));
      add(3'b100, 3'b100, 1'b0, 1'b1, ex(3'b100, 3'b100, 1'b0, 3'd0));
      add(3'b100, 3'b001, 1'b0, 1'b0, ex(3'b100, 3'b001, 1'b0, 3'd0));
      add(3'b100, 3'b100, 1'b0, 1'b1, ex(3'b100, 3'b100, 1'b0, 3'd0));
      for (int f = 0; f < 3; f++) begin
         add(3'b011, 3'b100, 1'b0, 1'b0, ex(3'b001, 3'b100, 1'b1, 3'd1));
         add(3'b100, 3'b100, 1'b1, 1'b0, ex(3'b100, 3'b100, 1'b0, 3'd1));
         for (int k = 0; k < 7; k++) add(3'b010, 3'b100, 1'b0, 1'b0, ex(3'b100, 3'b100, 1'b0, 3'd1));
         add(3'b010, 3'b100, 1'b0, 1'b0, ex(3'b100, 3'b100, 1'b0, 3'd0));
         nfaults++;
      end
      while (step_q.size() != 0) begin
         s = step_q.pop_front();
         in_1 = s.i1; in_2 = s.i2; ack = s.a; rs = s.r;
         exp_q.push_back(s.e);
         n++;
         @(posedge clk);
         #1;
         want = exp_q.pop_front();
         got  = {out_1, out_2, fault, fault_code};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL reset_mid step=%0d got=%b/%b f=%b c=%0d want=%b/%b f=%b c=%0d", n,
                     got[9:7], got[6:4], got[3], got[2:0],
                     want[9:7], want[6:4], want[3], want[2:0]);
         end
      end
`ifdef FAULT_CNT_EN
      total++;
      if (fault_cnt !== 8'(nfaults)) begin
         bad++;
         $display("FAIL fault_cnt_count got=%0d want=%0d", fault_cnt, nfaults);
      end
      rs = 1'b1;
      @(posedge clk);
      #1;
      rs = 1'b0;
      total++;
      if (fault_cnt !== 8'd0) begin
         bad++;
         $display("FAIL fault_cnt_reset got=%0d want=0", fault_cnt);
      end
`else
      if (nfaults != 3) $display("note: unexpected fault loop count %0d", nfaults);
`endif
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rs    = 1'b1;
      ack   = 1'b0;
      in_1  = 3'b100;
      in_2  = 3'b100;
      test_reset();
      test_pass_through();
      test_flash();
      test_code_priority();
      test_transitions();
      test_stuck_and_recover();
      test_recover_wait();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
